// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: accepts one read/byte-masked write per handshake and acknowledges after LATENCY cycles.
// Optional macro DSRAM_RAND_DELAY_EN adds LFSR-driven extra latency and IDLE back-pressure.
module data_sram_responder #(
   parameter int          ADDR_W    = 12,
   parameter int          LATENCY   = 1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);

   localparam int CNT_W = 5;
   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t            state_r;
   logic [CNT_W-1:0]  cnt_r;
   logic [CNT_W-1:0]  load_s;
   logic              wr_r;
   logic [ADDR_W-1:0] idx_r;
   logic [ADDR_W-1:0] idx_s;
   logic              accept_s;
   logic              data_ok_r;
   logic [31:0]       rdata_r;
   logic [1:0]        extra_s;
   logic              mask_s;
   logic              unused_addr_s;
   logic [31:0]       mem_r [DEPTH];

`ifdef DSRAM_RAND_DELAY_EN
   logic [15:0] lfsr_r;

   // Free-running Fibonacci LFSR, taps 16,14,13,11
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         lfsr_r <= LFSR_SEED;
      end else begin
         lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      end
   end

   assign extra_s = lfsr_r[1:0];
   assign mask_s  = lfsr_r[2];
`else
   assign extra_s = 2'b00;
   assign mask_s  = 1'b0;
`endif

   // Handshake decode and latency load value
   always_comb begin
      idx_s             = data_sram_addr[ADDR_W+1:2];
      unused_addr_s     = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
      data_sram_addr_ok = 1'b0;
      if (!resetn) begin
         data_sram_addr_ok = 1'b0;
      end else begin
         case (state_r)
            RESP:    data_sram_addr_ok = 1'b1;
            IDLE:    data_sram_addr_ok = ~mask_s;
            default: data_sram_addr_ok = 1'b0;
         endcase
      end
      accept_s = data_sram_req & data_sram_addr_ok;
      load_s   = CNT_W'(LATENCY - 1) + {{(CNT_W-2){1'b0}}, extra_s};
   end

   // Writes commit at the accept edge so a following read sees them
   always_ff @(posedge clk) begin
      if (accept_s && data_sram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wstrb[i]) begin
               mem_r[idx_s][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
         end
      end
   end

   // Transaction FSM; rdata is captured on the edge that enters RESP
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r   <= IDLE;
         cnt_r     <= {CNT_W{1'b0}};
         wr_r      <= 1'b0;
         idx_r     <= {ADDR_W{1'b0}};
         data_ok_r <= 1'b0;
         rdata_r   <= 32'h0000_0000;
      end else begin
         data_ok_r <= 1'b0;
         case (state_r)
            IDLE, RESP: begin
               if (accept_s) begin
                  wr_r  <= data_sram_wr;
                  idx_r <= idx_s;
                  if (load_s == {CNT_W{1'b0}}) begin
                     state_r   <= RESP;
                     cnt_r     <= {CNT_W{1'b0}};
                     data_ok_r <= 1'b1;
                     if (!data_sram_wr) begin
                        rdata_r <= mem_r[idx_s];
                     end
                  end else begin
                     state_r <= BUSY;
                     cnt_r   <= load_s;
                  end
               end else begin
                  state_r <= IDLE;
               end
            end
            BUSY: begin
               if (cnt_r == CNT_W'(1)) begin
                  state_r   <= RESP;
                  cnt_r     <= {CNT_W{1'b0}};
                  data_ok_r <= 1'b1;
                  if (!wr_r) begin
                     rdata_r <= mem_r[idx_r];
                  end
               end else begin
                  cnt_r <= cnt_r - CNT_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= {CNT_W{1'b0}};
            end
         endcase
      end
   end

   assign data_sram_data_ok = data_ok_r;
   assign data_sram_rdata   = rdata_r;

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Data-side memory responder: the far end of the CPU data SRAM port driven by the execute stage.
- Accepts one request per handshake (read or byte-masked write) and holds it in an internal word array.
- Returns a data_ok acknowledge, with read data, after a programmable latency.
- Used as the data memory model in simulation and in the local FPGA environment, so that pipeline stall and handshake logic is exercised.

Parameters:
- ADDR_W, 12, word-index width; array depth is 2**ADDR_W 32-bit words.
- LATENCY, 1, cycles from the accept edge to data_ok high; legal range 1..15.
- LFSR_SEED, 16'hACE1, reset value of the delay LFSR (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = write, 0 = read.
- data_sram_wstrb  in  4  byte write enables, bit i selects wdata[8i+7:8i]; ignored for reads.
- data_sram_addr  in  32  byte address; word index = addr[ADDR_W+1:2].
- data_sram_wdata  in  32  write data.
- data_sram_addr_ok  out  1  request accepted this cycle when req is also 1.
- data_sram_data_ok  out  1  one-cycle response pulse (read data valid, or write ack).
- data_sram_rdata  out  32  read data, registered.

Behaviour:
- Reset (resetn low, asynchronous):
  - state = IDLE, counter = 0, data_ok = 0, rdata = 0.
  - addr_ok = 0 while resetn is low.
  - Array contents are not reset and are preserved across reset.
- States: IDLE, BUSY, RESP.
- addr_ok = resetn & (state==IDLE | state==RESP), combinational from state.
- Accept = req & addr_ok at a rising edge. On accept, latch wr and word index.
- Write: committed to the array at the accept edge. Bytes with wstrb bit 0 are unchanged; wstrb=0 writes nothing but is still acknowledged.
- Read: the array is read at the edge entering RESP, into rdata.
- Transitions:
  - On accept with LATENCY==1: go to RESP.
  - On accept with LATENCY>1: go to BUSY, counter = LATENCY-1.
  - BUSY: counter decrements each cycle; when counter==1, go to RESP at the next edge.
  - RESP: data_ok = 1 for exactly this cycle. If a new accept occurs in RESP, follow the accept rule above; otherwise go to IDLE.
- Timing: data_ok rises LATENCY cycles after the accept edge.
  - LATENCY=1 sustains one request per cycle.
  - LATENCY=N sustains one request per N cycles.
- Ordering: one transaction outstanding at a time; responses are strictly in order.
- Read-after-write to the same word returns the new data, because the write commits at its accept edge.
- rdata:
  - Updated only on read responses.
  - Holds its value through write responses and idle cycles.
  - Undefined-content reads return whatever is in the array.
- Address aliasing:
  - Address bits above ADDR_W+1 are ignored, so the array wraps.
  - addr[1:0] is ignored (always word access).
- Reset mid-transaction:
  - The pending response is dropped; no data_ok follows.
  - A write already accepted before reset stays committed.
- req held while addr_ok=0 is not accepted; the requester keeps it stable.

Optional Feature:
- Macro: DSRAM_RAND_DELAY_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11), reset to LFSR_SEED, advances every cycle.
  - On accept, the counter loads LATENCY-1 + lfsr[1:0], adding 0..3 extra wait cycles.
  - In IDLE, addr_ok is additionally masked when lfsr[2]==1, giving random back-pressure.
  - Ordering and data semantics are unchanged.
- When undefined: no LFSR logic; latency is exactly LATENCY and addr_ok is never masked in IDLE/RESP.

Test Plan:
- Basic write then read (LATENCY=1): write addr 0x10, wstrb 4'hF, wdata 0x12345678; then read 0x10 → data_ok one cycle after each accept; read rdata=0x12345678.
- Byte write: after the above, write 0x10, wstrb 4'b0010, wdata 0x0000AB00; then read → rdata=0x1234AB78.
- LATENCY=3: accept read at edge t → addr_ok=0 for cycles t+1..t+2; data_ok=1 only in cycle t+3; addr_ok=1 again in t+3.
- Back-to-back (LATENCY=1): req held high with reads of 0x0, 0x4, 0x8 (preloaded 1, 2, 3) → data_ok high on three consecutive cycles; rdata 1, 2, 3 in order.
- Reset mid-BUSY (LATENCY=4): accept a read, pull resetn low for 2 cycles in BUSY → data_ok stays 0; rdata=0; addr_ok=1 on release; word written earlier still reads back unchanged.
- Wrap (ADDR_W=12): write 0xCAFEF00D to 0x4000, read 0x0 → 0xCAFEF00D; with DSRAM_RAND_DELAY_EN, 100 random transactions → every read matches the scoreboard; data_ok latency stays within LATENCY..LATENCY+3.
